// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for the in-order pipeline. It decides when the front end
// stalls, when bubbles are injected, and when EX is frozen for a multi-cycle
// (mul/div) operation.
//
//   - Taken branch or jump in EX: flush IF-ID and ID-EX.
//   - Multi-cycle op issued in EX: freeze the front end and EX until md_done
//     arrives or a 64-cycle timeout expires. Then spend one MD_DONE cycle with
//     the front end still held and EX released, and return to RUN.
//   - Load-use: stall the front end for one cycle and inject a bubble into
//     ID-EX.
//
// Ports
//   CLK                     clock, rising edge
//   Resetn                  synchronous active-low reset
//   id_rs1, id_rs2          [5:0] source registers of the instruction in ID
//   id_use_rs1, id_use_rs2  ID instruction actually reads rs1 / rs2
//   ex_rd                   [5:0] destination register of the instruction in EX
//   ex_MemtoReg, ex_RegWr   EX is a load / EX writes a register
//   ex_redirect             branch taken or jump resolved in EX
//   md_start, md_done       multi-cycle op issued / result ready
//   pc_en, ifid_en          PC and IF-ID write enables
//   ifid_flush, idex_flush  bubble into IF-ID / ID-EX on the next update
//   ex_hold                 freeze EX and EX-MEM
//   md_timeout              sticky: a multi-cycle op never signalled done
//   state                   [1:0] RUN=00, MD_WAIT=01, MD_DONE=10
//   stall_cnt, flush_cnt    [31:0] saturating performance counters
//                           (present only when HAZARD_PERF_CNT_EN is defined)
//
// Build option: define HAZARD_PERF_CNT_EN to add the performance counters.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl (
   input  logic        CLK,
   input  logic        Resetn,
   input  logic [5:0]  id_rs1,
   input  logic [5:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [5:0]  ex_rd,
   input  logic        ex_MemtoReg,
   input  logic        ex_RegWr,
   input  logic        ex_redirect,
   input  logic        md_start,
   input  logic        md_done,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        ex_hold,
   output logic        md_timeout,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
`endif
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      MD_WAIT = 2'b01,
      MD_DONE = 2'b10
   } state_t;

   state_t     state_reg, state_next;
   logic [5:0] to_cnt_reg, to_cnt_next;
   logic       md_timeout_reg, md_timeout_next;
   logic       load_use;

   // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign load_use = ex_MemtoReg & ex_RegWr & (ex_rd != 6'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      pc_en           = 1'b1;
      ifid_en         = 1'b1;
      ifid_flush      = 1'b0;
      idex_flush      = 1'b0;
      ex_hold         = 1'b0;
      state_next      = state_reg;
      to_cnt_next     = to_cnt_reg;
      md_timeout_next = md_timeout_reg;

      case (state_reg)
         RUN: begin
            if (ex_redirect) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (md_start) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_flush  = 1'b1;
               ex_hold     = 1'b1;
               to_cnt_next = 6'd0;
               state_next  = MD_WAIT;
            end else if (load_use) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end
         end
         MD_WAIT: begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            ex_hold     = 1'b1;
            to_cnt_next = to_cnt_reg + 6'd1;
            if (md_done) begin
               state_next = MD_DONE;
            end else if (to_cnt_reg == 6'd63) begin
               // 64th wait cycle with no result: give up, keep the evidence.
               md_timeout_next = 1'b1;
               state_next      = MD_DONE;
            end
         end
         MD_DONE: begin
            // EX writes back the result this cycle; front end holds one more.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            state_next = RUN;
         end
         default: begin
            state_next = RUN;
         end
      endcase

      // Reset overrides everything so nothing leaks into the pipe registers.
      if (!Resetn) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         ex_hold    = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!Resetn) begin
         state_reg      <= RUN;
         to_cnt_reg     <= 6'd0;
         md_timeout_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         to_cnt_reg     <= to_cnt_next;
         md_timeout_reg <= md_timeout_next;
      end
   end

   assign state      = state_reg;
   assign md_timeout = md_timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;
   logic [31:0] flush_cnt_reg;
   logic        redirect_flush;

   assign redirect_flush = (state_reg == RUN) & ex_redirect;

   always_ff @(posedge CLK) begin
      if (!Resetn) begin
         stall_cnt_reg <= 32'd0;
         flush_cnt_reg <= 32'd0;
      end else begin
         if (!pc_en && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (redirect_flush && (flush_cnt_reg != 32'hFFFF_FFFF))
            flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. Each step drives one cycle of
// inputs, pushes the expected output word onto a scoreboard queue, and pops
// and compares it against the DUT at the falling edge.
// Output word: {state[1:0], md_timeout, pc_en, ifid_en, ifid_flush,
//               idex_flush, ex_hold}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        Resetn;
   logic [5:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_MemtoReg, ex_RegWr;
   logic        ex_redirect, md_start, md_done;
   logic        pc_en, ifid_en, ifid_flush, idex_flush, ex_hold, md_timeout;
   logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   pipe_hazard_ctrl dut (
      .CLK         (clk),
      .Resetn      (Resetn),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_MemtoReg (ex_MemtoReg),
      .ex_RegWr    (ex_RegWr),
      .ex_redirect (ex_redirect),
      .md_start    (md_start),
      .md_done     (md_done),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .ex_hold     (ex_hold),
      .md_timeout  (md_timeout),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
`endif
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rn;
      logic [5:0] rs1;
      logic [5:0] rs2;
      logic       u1;
      logic       u2;
      logic [5:0] rd;
      logic       mtr;
      logic       rw;
      logic       redir;
      logic       mds;
      logic       mdd;
   } stim_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   string       tag_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   function automatic stim_t mk(input logic [5:0] rs1, input logic [5:0] rs2,
                                input logic u1, input logic u2, input logic [5:0] rd,
                                input logic mtr, input logic rw, input logic redir,
                                input logic mds, input logic mdd);
      stim_t s;
      s.rn = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
      s.mtr = mtr; s.rw = rw; s.redir = redir; s.mds = mds; s.mdd = mdd;
      return s;
   endfunction

   function automatic stim_t idle();
      return mk(6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic stim_t with_reset(input stim_t s);
      stim_t r;
      r = s;
      r.rn = 1'b0;
      return r;
   endfunction

   // Expected output words
   function automatic logic [7:0] ew(input logic [1:0] st, input logic tmo, input logic pc,
                                     input logic fi, input logic ff, input logic df, input logic h);
      return {st, tmo, pc, fi, ff, df, h};
   endfunction
   function automatic logic [7:0] e_run(input logic t);   return ew(2'b00, t, 1, 1, 0, 0, 0); endfunction
   function automatic logic [7:0] e_lu(input logic t);    return ew(2'b00, t, 0, 0, 0, 1, 0); endfunction
   function automatic logic [7:0] e_redir(input logic t); return ew(2'b00, t, 1, 1, 1, 1, 0); endfunction
   function automatic logic [7:0] e_mds(input logic t);   return ew(2'b00, t, 0, 0, 0, 1, 1); endfunction
   function automatic logic [7:0] e_wait(input logic t);  return ew(2'b01, t, 0, 0, 0, 1, 1); endfunction
   function automatic logic [7:0] e_done(input logic t);  return ew(2'b10, t, 0, 0, 0, 0, 0); endfunction
   function automatic logic [7:0] e_rst(input logic [1:0] st, input logic t);
      return ew(st, t, 0, 0, 1, 1, 0);
   endfunction

   task automatic apply(input stim_t s);
      Resetn      = s.rn;
      id_rs1      = s.rs1;
      id_rs2      = s.rs2;
      id_use_rs1  = s.u1;
      id_use_rs2  = s.u2;
      ex_rd       = s.rd;
      ex_MemtoReg = s.mtr;
      ex_RegWr    = s.rw;
      ex_redirect = s.redir;
      md_start    = s.mds;
      md_done     = s.mdd;
   endtask

   task automatic step(input string tag, input stim_t s, input logic [7:0] e);
      logic [7:0] got;
      apply(s);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      got = {state, md_timeout, pc_en, ifid_en, ifid_flush, idex_flush, ex_hold};
      check_val(tag_q.pop_front(), {24'd0, got}, {24'd0, exp_q.pop_front()});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t lu5, lu7;
      lu5 = mk(6'd0, 6'd5, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      lu7 = mk(6'd7, 6'd0, 1'b1, 1'b0, 6'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      apply(with_reset(idle()));
      repeat (2) @(posedge clk);
      #1;

      // Reset dominates any activity on the inputs
      begin
         stim_t s;
         s = lu5; s.redir = 1'b1; s.mds = 1'b1;
         step("rst_busy_inputs", with_reset(s), e_rst(2'b00, 1'b0));
      end

      // 3 redirects + 1 load-use stall for the perf counters
      begin
         stim_t r;
         r = idle(); r.redir = 1'b1;
         step("perf_redir1", r, e_redir(0));
         step("perf_redir2", r, e_redir(0));
         step("perf_lu", lu5, e_lu(0));
         step("perf_redir3", r, e_redir(0));
         step("perf_idle", idle(), e_run(0));
`ifdef HAZARD_PERF_CNT_EN
         check_val("flush_cnt", flush_cnt, 32'd3);
         check_val("stall_cnt", stall_cnt, 32'd1);
`endif
      end

      // Load-use detection
      step("lu_rs2", lu5, e_lu(0));
      step("lu_after_idle", idle(), e_run(0));
      begin
         stim_t s;
         s = lu5; s.rs2 = 6'd0; s.rd = 6'd0;
         step("lu_rd0", s, e_run(0));
         s = lu7; s.u1 = 1'b0;
         step("lu_rs1_unused", s, e_run(0));
         step("lu_rs1", lu7, e_lu(0));
         s = lu7; s.rw = 1'b0;
         step("lu_no_regwr", s, e_run(0));
         s = lu7; s.mtr = 1'b0;
         step("lu_not_load", s, e_run(0));
         s = lu7; s.rd = 6'd8;
         step("lu_reg_differs", s, e_run(0));

         // Priority
         s = lu5; s.redir = 1'b1;
         step("redir_over_lu", s, e_redir(0));
         s = idle(); s.redir = 1'b1; s.mds = 1'b1;
         step("redir_over_mds", s, e_redir(0));
         step("still_run", idle(), e_run(0));
         s = lu5; s.mds = 1'b1;
         step("mds_over_lu", s, e_mds(0));

         // MD_WAIT ignores redirect/load-use; md_done on the 4th wait cycle
         s = lu5; s.redir = 1'b1;
         step("wait1_ignore", s, e_wait(0));
         step("wait2", idle(), e_wait(0));
         step("wait3", idle(), e_wait(0));
         s = idle(); s.mdd = 1'b1;
         step("wait4_done", s, e_wait(0));
         step("md_done_state", s, e_done(0));
         step("run_md_done_ign", s, e_run(0));
         step("run_stays", idle(), e_run(0));

         // md_done on the first wait cycle
         s = idle(); s.mds = 1'b1;
         step("early_mds", s, e_mds(0));
         s = idle(); s.mdd = 1'b1;
         step("early_wait_done", s, e_wait(0));
         step("early_md_done", idle(), e_done(0));
         step("early_run", idle(), e_run(0));

         // Reset in the middle of MD_WAIT
         s = idle(); s.mds = 1'b1;
         step("rstw_mds", s, e_mds(0));
         step("rstw_wait1", idle(), e_wait(0));
         step("rstw_wait2", idle(), e_wait(0));
         s = idle(); s.redir = 1'b1;
         step("rstw_reset", with_reset(s), e_rst(2'b01, 1'b0));
         step("rstw_run", idle(), e_run(0));

         // Timeout: 64 wait cycles with no md_done
         s = idle(); s.mds = 1'b1;
         step("to_mds", s, e_mds(0));
         for (int i = 0; i < 64; i++)
            step($sformatf("to_wait%0d", i), idle(), e_wait(0));
         step("to_md_done", idle(), e_done(1));
         step("to_run", idle(), e_run(1));
         s = idle(); s.mdd = 1'b1;
         step("to_run_held", s, e_run(1));
         s = idle(); s.mds = 1'b1;
         step("to2_mds", s, e_mds(1));
         s = idle(); s.mdd = 1'b1;
         step("to2_wait_done", s, e_wait(1));
         step("to2_md_done", idle(), e_done(1));
         step("to2_run_held", idle(), e_run(1));
         step("to_reset", with_reset(idle()), e_rst(2'b00, 1'b1));
         step("to_cleared", idle(), e_run(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
